// File: rtl/parallel2serial_tx.sv
// rtl/parallel2serial_tx.sv - parallel-to-serial word transmitter with one-word holding buffer
// Shifts each WIDTH-bit word out one bit per cycle, with optional forced idle gap between words.
module parallel2serial_tx #(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 1,
   parameter int GAP       = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din_parallel,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             dout_serial,
   output logic             dout_valid,
   output logic             frame_last,
   output logic             busy
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [WIDTH-1:0] buf_q, buf_d;
   logic             buf_full_q, buf_full_d;
   logic [CW-1:0]    bitcnt_q, bitcnt_d;
   logic [3:0]       gapcnt_q, gapcnt_d;

   logic             accept;
   logic             avail;
   logic             load;
   logic             last_bit;
   logic [WIDTH-1:0] next_word;

   assign accept    = din_valid && !buf_full_q;
   assign avail     = buf_full_q || accept;
   assign next_word = buf_full_q ? buf_q : din_parallel;
   assign last_bit  = (bitcnt_q == CW'(WIDTH - 1));

   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      buf_d      = buf_q;
      buf_full_d = buf_full_q;
      bitcnt_d   = bitcnt_q;
      gapcnt_d   = gapcnt_q;
      load       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (avail) load = 1'b1;
         end
         S_SHIFT: begin
            shreg_d  = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);
            bitcnt_d = bitcnt_q + CW'(1);
            if (last_bit) begin
               if (GAP > 0) begin
                  state_d  = S_GAP;
                  gapcnt_d = 4'(GAP);
               end else if (avail) begin
                  load = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_GAP: begin
            if (gapcnt_q <= 4'd1) begin
               if (avail) load = 1'b1;
               else       state_d = S_IDLE;
            end else begin
               gapcnt_d = gapcnt_q - 4'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Buffer has load priority; a word that is not loaded straight in parks in the buffer.
      if (load) begin
         state_d  = S_SHIFT;
         shreg_d  = next_word;
         bitcnt_d = '0;
      end
      if (load && buf_full_q) begin
         buf_full_d = 1'b0;
      end else if (accept && !load) begin
         buf_d      = din_parallel;
         buf_full_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         shreg_q    <= '0;
         buf_q      <= '0;
         buf_full_q <= 1'b0;
         bitcnt_q   <= '0;
         gapcnt_q   <= '0;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         buf_q      <= buf_d;
         buf_full_q <= buf_full_d;
         bitcnt_q   <= bitcnt_d;
         gapcnt_q   <= gapcnt_d;
      end
   end

   assign din_ready   = !buf_full_q;
   assign dout_valid  = (state_q == S_SHIFT);
   assign dout_serial = dout_valid && ((MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0]);
   assign frame_last  = dout_valid && last_bit;
   assign busy        = (state_q != S_IDLE) || buf_full_q;

endmodule

// File: tb/tb_parallel2serial_tx.sv
// tb/tb_parallel2serial_tx.sv - scoreboard bench for parallel2serial_tx
// Three instances: MSB-first GAP=1, MSB-first GAP=0, LSB-first GAP=0.
module tb_parallel2serial_tx;
   typedef struct packed {
      logic b;
      logic last;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] din_p [3];
   logic       din_v [3];
   logic       din_r [3];
   logic       ser   [3];
   logic       dv    [3];
   logic       fl    [3];
   logic       bsy   [3];

   exp_t sbq [3][$];
   int   ncmp  = 0;
   int   nfail = 0;

   int   runs   [3][0:255];
   int   gaps   [3][0:255];
   int   n_runs [3];
   int   n_gaps [3];
   int   run_len[3];
   int   gap_len[3];
   logic prev_v [3];
   logic had_run[3];

   always #5 clk = ~clk;

   parallel2serial_tx #(.WIDTH(8), .MSB_FIRST(1), .GAP(1)) u_msb_gap1 (
      .clk(clk), .rst(rst), .din_parallel(din_p[0]), .din_valid(din_v[0]),
      .din_ready(din_r[0]), .dout_serial(ser[0]), .dout_valid(dv[0]),
      .frame_last(fl[0]), .busy(bsy[0]));

   parallel2serial_tx #(.WIDTH(8), .MSB_FIRST(1), .GAP(0)) u_msb_gap0 (
      .clk(clk), .rst(rst), .din_parallel(din_p[1]), .din_valid(din_v[1]),
      .din_ready(din_r[1]), .dout_serial(ser[1]), .dout_valid(dv[1]),
      .frame_last(fl[1]), .busy(bsy[1]));

   parallel2serial_tx #(.WIDTH(8), .MSB_FIRST(0), .GAP(0)) u_lsb_gap0 (
      .clk(clk), .rst(rst), .din_parallel(din_p[2]), .din_valid(din_v[2]),
      .din_ready(din_r[2]), .dout_serial(ser[2]), .dout_valid(dv[2]),
      .frame_last(fl[2]), .busy(bsy[2]));

   // Monitor: pops one expected bit per valid cycle; also records valid run and gap lengths.
   initial begin
      for (int d = 0; d < 3; d++) begin
         n_runs[d] = 0; n_gaps[d] = 0; run_len[d] = 0; gap_len[d] = 0;
         prev_v[d] = 1'b0; had_run[d] = 1'b0;
      end
   end

   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         exp_t e;
         if (dv[d] === 1'b1) begin
            ncmp++;
            if (sbq[d].size() == 0) begin
               nfail++;
               $display("FAIL unexpected_bit dut%0d: dout_valid=1 but no word outstanding", d);
            end else begin
               e = sbq[d].pop_front();
               if ({ser[d], fl[d]} !== {e.b, e.last}) begin
                  nfail++;
                  $display("FAIL serial_bit dut%0d: got serial=%b last=%b, expected serial=%b last=%b",
                           d, ser[d], fl[d], e.b, e.last);
               end
            end
         end else begin
            ncmp++;
            if (ser[d] !== 1'b0 || fl[d] !== 1'b0 || dv[d] !== 1'b0) begin
               nfail++;
               $display("FAIL idle_quiet dut%0d: got valid=%b serial=%b last=%b, expected 0 0 0",
                        d, dv[d], ser[d], fl[d]);
            end
         end
         if (rst) sbq[d].delete();

         if (dv[d] === 1'b1) begin
            if (!prev_v[d] && had_run[d]) begin
               gaps[d][n_gaps[d] % 256] = gap_len[d];
               n_gaps[d]++;
            end
            run_len[d]++;
            gap_len[d] = 0;
         end else begin
            if (prev_v[d]) begin
               runs[d][n_runs[d] % 256] = run_len[d];
               n_runs[d]++;
               run_len[d] = 0;
               had_run[d] = 1'b1;
            end
            gap_len[d]++;
         end
         prev_v[d] = (dv[d] === 1'b1);
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Called on a negedge; returns on the negedge following the accepting edge.
   task automatic send(input int d, input logic [7:0] w, input logic [7:0] order);
      int t;
      t = 0;
      din_p[d] = w;
      din_v[d] = 1'b1;
      while (din_r[d] !== 1'b1 && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (din_r[d] !== 1'b1) begin
         ncmp++;
         nfail++;
         $display("FAIL send_timeout dut%0d: din_ready stayed %b, expected 1", d, din_r[d]);
         din_v[d] = 1'b0;
         return;
      end
      for (int i = 7; i >= 0; i--) sbq[d].push_back('{b: order[i], last: (i == 0)});
      @(negedge clk);
      din_v[d] = 1'b0;
   endtask

   task automatic wait_idle(input int d);
      int t;
      t = 0;
      while ((bsy[d] !== 1'b0 || sbq[d].size() != 0) && t < 400) begin
         @(negedge clk);
         t++;
      end
      chk($sformatf("idle_reached_dut%0d", d), int'(bsy[d] === 1'b0 && sbq[d].size() == 0), 1);
      @(negedge clk);
      @(negedge clk);
   endtask

   function automatic logic [7:0] rev8(input logic [7:0] w);
      for (int i = 0; i < 8; i++) rev8[i] = w[7-i];
   endfunction

   initial begin
      int rb, gb, vcount;
      logic [7:0] w;
      for (int d = 0; d < 3; d++) begin
         din_p[d] = 8'h00;
         din_v[d] = 1'b0;
      end

      // Reset state
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("rst_din_ready_dut%0d", d), int'(din_r[d]), 1);
         chk($sformatf("rst_dout_valid_dut%0d", d), int'(dv[d]), 0);
         chk($sformatf("rst_busy_dut%0d", d), int'(bsy[d]), 0);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // 1: single word, one-cycle latency, one 8-cycle burst
      rb = n_runs[0];
      send(0, 8'hA5, 8'b1010_0101);
      chk("t1_latency_valid", int'(dv[0]), 1);
      wait_idle(0);
      chk("t1_run_count", n_runs[0] - rb, 1);
      chk("t1_run_len", runs[0][rb % 256], 8);

      // 2: back-to-back offer with GAP=1, second word buffered
      rb = n_runs[0];
      gb = n_gaps[0];
      send(0, 8'h3C, 8'b0011_1100);
      send(0, 8'hC3, 8'b1100_0011);
      chk("t2_ready_low_while_buffered", int'(din_r[0]), 0);
      chk("t2_busy", int'(bsy[0]), 1);
      wait_idle(0);
      chk("t2_run_count", n_runs[0] - rb, 2);
      chk("t2_run0_len", runs[0][rb % 256], 8);
      chk("t2_run1_len", runs[0][(rb + 1) % 256], 8);
      chk("t2_gap_len", gaps[0][(gb + 1) % 256], 1);

      // 3: GAP=0 stream of three words, no bubble
      rb = n_runs[1];
      send(1, 8'h96, 8'b1001_0110);
      send(1, 8'h0F, 8'b0000_1111);
      send(1, 8'hF0, 8'b1111_0000);
      wait_idle(1);
      chk("t3_run_count", n_runs[1] - rb, 1);
      chk("t3_run_len", runs[1][rb % 256], 24);

      // 4: LSB-first
      send(2, 8'h01, 8'b1000_0000);
      send(2, 8'hC1, 8'b1000_0011);
      wait_idle(2);

      // 5: reset mid-word with a word buffered
      send(0, 8'hFF, 8'b1111_1111);
      send(0, 8'hAA, 8'b1010_1010);
      repeat (3) @(negedge clk);
      chk("t5_valid_before_rst", int'(dv[0]), 1);
      rst = 1'b1;
      @(negedge clk);
      chk("t5_valid_after_rst", int'(dv[0]), 0);
      chk("t5_busy_after_rst", int'(bsy[0]), 0);
      chk("t5_ready_after_rst", int'(din_r[0]), 1);
      rst = 1'b0;
      vcount = 0;
      repeat (20) begin
         @(negedge clk);
         if (dv[0] === 1'b1) vcount++;
      end
      chk("t5_no_resume", vcount, 0);

      // 6: random words with random offer gaps
      for (int i = 0; i < 256; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         w = 8'($urandom);
         send(0, w, w);
      end
      wait_idle(0);
      for (int i = 0; i < 64; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         w = 8'($urandom);
         send(2, w, rev8(w));
      end
      wait_idle(2);

      for (int d = 0; d < 3; d++) chk($sformatf("sb_empty_dut%0d", d), sbq[d].size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule
